axi_lite_write_arbiter: RTL and testbench

Round-robin arbiter that shares a single AXI-Lite write slave (e.g. a write FIFO or control-register block) among NUM_MASTERS AXI-Lite write masters. Grants one master at a time, routes its AW and W channels to the shared slave, returns the B response to the same master, and only then re-arbitrates. Write transactions are never interleaved.

---
 rtl/axi_lite_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axi_lite_write_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_write_arbiter.sv
// Shares one AXI-Lite write slave among NUM_MASTERS masters, one complete AW/W/B transaction at a time.
// AXI_WRITE_ARB_RR_EN selects round-robin arbitration; without it the lowest-index requester always wins.
//
// state | meaning
// IDLE  | no grant; pick a winner from the pending requests
// XFER  | granted master's AW and W routed to the slave until both have handshaken
// RESP  | slave B response routed back to the granted master
module axi_lite_write_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int BUS_WIDTH   = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_MASTERS-1:0]               s_axi_awvalid,
    output logic [NUM_MASTERS-1:0]               s_axi_awready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic [NUM_MASTERS*3-1:0]             s_axi_awprot,
    input  logic [NUM_MASTERS-1:0]               s_axi_wvalid,
    output logic [NUM_MASTERS-1:0]               s_axi_wready,
    input  logic [NUM_MASTERS*BUS_WIDTH-1:0]     s_axi_wdata,
    input  logic [NUM_MASTERS*BUS_WIDTH/8-1:0]   s_axi_wstrb,
    output logic [NUM_MASTERS-1:0]               s_axi_bvalid,
    input  logic [NUM_MASTERS-1:0]               s_axi_bready,
    output logic [NUM_MASTERS*2-1:0]             s_axi_bresp,

    output logic                                 m_axi_awvalid,
    input  logic                                 m_axi_awready,
    output logic [ADDR_WIDTH-1:0]                m_axi_awaddr,
    output logic [2:0]                           m_axi_awprot,
    output logic                                 m_axi_wvalid,
    input  logic                                 m_axi_wready,
    output logic [BUS_WIDTH-1:0]                 m_axi_wdata,
    output logic [BUS_WIDTH/8-1:0]               m_axi_wstrb,
    input  logic                                 m_axi_bvalid,
    output logic                                 m_axi_bready,
    input  logic [1:0]                           m_axi_bresp,

    output logic [NUM_MASTERS-1:0]               grant,
    output logic                                 busy
);

    localparam int IDX_WIDTH  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_WIDTH-1:0]   gidx;
    logic                   aw_done;
    logic                   w_done;
    logic [NUM_MASTERS-1:0] req;
    logic                   win_found;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;
    logic                   xfer_complete;

    assign req           = s_axi_awvalid | s_axi_wvalid;
    assign aw_hs         = m_axi_awvalid & m_axi_awready;
    assign w_hs          = m_axi_wvalid & m_axi_wready;
    assign b_hs          = m_axi_bvalid & m_axi_bready;
    assign xfer_complete = (aw_done | aw_hs) & (w_done | w_hs);
    assign busy          = (state != IDLE);

`ifdef AXI_WRITE_ARB_RR_EN
    logic [IDX_WIDTH-1:0] last;
    logic [IDX_WIDTH-1:0] cand;

    // search begins just after the previous winner so every requester is served in turn
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand = IDX_WIDTH'((int'(last) + off) % NUM_MASTERS);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_WIDTH'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            gidx    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef AXI_WRITE_ARB_RR_EN
            last    <= IDX_WIDTH'(NUM_MASTERS - 1);
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gidx  <= win_idx;
                        grant <= NUM_MASTERS'(1) << win_idx;
                    end
                end
                XFER: begin
                    if (xfer_complete) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        grant <= '0;
`ifdef AXI_WRITE_ARB_RR_EN
                        last  <= gidx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found)     state_next = XFER;
            XFER:    if (xfer_complete) state_next = RESP;
            RESP:    if (b_hs)          state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // data paths are forced to zero outside their phase so idle outputs stay quiet
    always_comb begin
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bvalid  = '0;
        s_axi_bresp   = '0;
        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_awprot  = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_bready  = 1'b0;
        case (state)
            XFER: begin
                m_axi_awvalid        = s_axi_awvalid[gidx] & ~aw_done;
                m_axi_awaddr         = s_axi_awaddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
                m_axi_awprot         = s_axi_awprot[gidx*3 +: 3];
                s_axi_awready[gidx]  = m_axi_awready & ~aw_done;
                m_axi_wvalid         = s_axi_wvalid[gidx] & ~w_done;
                m_axi_wdata          = s_axi_wdata[gidx*BUS_WIDTH +: BUS_WIDTH];
                m_axi_wstrb          = s_axi_wstrb[gidx*STRB_WIDTH +: STRB_WIDTH];
                s_axi_wready[gidx]   = m_axi_wready & ~w_done;
            end
            RESP: begin
                s_axi_bvalid[gidx]       = m_axi_bvalid;
                s_axi_bresp[gidx*2 +: 2] = m_axi_bresp;
                m_axi_bready             = s_axi_bready[gidx];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Randomised bench for axi_lite_write_arbiter: stimulus pushes expected transactions, a negedge monitor checks them.
module tb_axi_lite_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int SW = BW / 8;
`ifdef AXI_WRITE_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
        logic [BW-1:0] data;
        logic [SW-1:0] strb;
    } tx_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [N-1:0]    s_axi_bvalid, s_axi_bready;
    logic [N*AW-1:0] s_axi_awaddr;
    logic [N*3-1:0]  s_axi_awprot;
    logic [N*BW-1:0] s_axi_wdata;
    logic [N*SW-1:0] s_axi_wstrb;
    logic [N*2-1:0]  s_axi_bresp;
    logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic            m_axi_bvalid, m_axi_bready;
    logic [AW-1:0]   m_axi_awaddr;
    logic [2:0]      m_axi_awprot;
    logic [BW-1:0]   m_axi_wdata;
    logic [SW-1:0]   m_axi_wstrb;
    logic [1:0]      m_axi_bresp;
    logic [N-1:0]    grant;
    logic            busy;

    axi_lite_write_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    tx_t exp_q[N][$];
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // winner = requester at the smallest rotational distance after the previous winner
    function automatic int pick(input logic [N-1:0] r, input int lst);
        int best = -1;
        int bd   = N + 1;
        int d;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = RR_MODE ? ((i - lst - 1 + 2 * N) % N) : i;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic quiet(input int g);
        logic q = 1'b0;
        for (int i = 0; i < N; i++)
            if (i != g) q |= s_axi_awready[i] | s_axi_wready[i] | s_axi_bvalid[i] | (|s_axi_bresp[i*2 +: 2]);
        if (g < 0) q |= m_axi_awvalid | m_axi_wvalid | m_axi_bready;
        return q;
    endfunction

    // ---------------- monitor / reference model ----------------
    initial begin : monitor
        bit           m_busy = 1'b0;
        int           mg = 0;
        int           mlast = N - 1;
        int           aw_cnt = 0;
        int           w_cnt = 0;
        bit           resp;
        logic [N-1:0] oh;
        tx_t          cur = '0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                m_busy = 1'b0;
                mlast  = N - 1;
                aw_cnt = 0;
                w_cnt  = 0;
            end else if (!m_busy) begin
                chk("idle_grant", 64'({busy, grant}), 64'd0);
                chk("idle_quiet", 64'(quiet(-1)), 64'd0);
                if ((s_axi_awvalid | s_axi_wvalid) != '0) begin
                    mg     = pick(s_axi_awvalid | s_axi_wvalid, mlast);
                    m_busy = 1'b1;
                    aw_cnt = 0;
                    w_cnt  = 0;
                    chk("exp_avail", 64'(exp_q[mg].size() != 0), 64'd1);
                    if (exp_q[mg].size() != 0) cur = exp_q[mg].pop_front();
                end
            end else begin
                resp = (aw_cnt == 1) && (w_cnt == 1);
                oh = '0;
                oh[mg] = 1'b1;
                chk("grant", 64'({busy, grant}), 64'({1'b1, oh}));
                chk("others_quiet", 64'(quiet(mg)), 64'd0);
                if (resp) begin
                    chk("b_route", 64'({s_axi_bvalid[mg], m_axi_bready, s_axi_bresp[mg*2 +: 2]}),
                        64'({m_axi_bvalid, s_axi_bready[mg], m_axi_bresp}));
                    chk("no_xfer_in_resp", 64'({m_axi_awvalid, m_axi_wvalid, s_axi_awready[mg], s_axi_wready[mg]}), 64'd0);
                    if (m_axi_bvalid && m_axi_bready) begin
                        chk("bresp", 64'(s_axi_bresp[mg*2 +: 2]), 64'(cur.addr[3:2]));
                        mlast  = mg;
                        m_busy = 1'b0;
                    end
                end else begin
                    chk("aw_gate", 64'({m_axi_awvalid, s_axi_awready[mg]}),
                        64'({s_axi_awvalid[mg] & (aw_cnt == 0), m_axi_awready & (aw_cnt == 0)}));
                    chk("w_gate", 64'({m_axi_wvalid, s_axi_wready[mg]}),
                        64'({s_axi_wvalid[mg] & (w_cnt == 0), m_axi_wready & (w_cnt == 0)}));
                    chk("b_hold", 64'({s_axi_bvalid[mg], m_axi_bready}), 64'd0);
                    if (m_axi_awvalid && m_axi_awready) begin
                        chk("awaddr", 64'(m_axi_awaddr), 64'(cur.addr));
                        chk("awprot", 64'(m_axi_awprot), 64'(cur.prot));
                        aw_cnt++;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        chk("wdata", 64'(m_axi_wdata), 64'(cur.data));
                        chk("wstrb", 64'(m_axi_wstrb), 64'(cur.strb));
                        w_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus: masters and slave model ----------------
    int      ph[N], gap[N], awd[N], wd[N], left[N];
    bit      aws[N], ws[N];
    tx_t     cur_tx[N];
    bit      s_gaw, s_gw;
    logic [AW-1:0] s_addr;
    int      s_bd, rdy_pct, brdy_pct, max_bd;

    task automatic step();
        logic [N-1:0]  awh, wh, bh;
        logic          sl_aw, sl_w, sl_b;
        logic [AW-1:0] cap_addr;
        tx_t           t;
        @(negedge clk);
        awh      = s_axi_awvalid & s_axi_awready;
        wh       = s_axi_wvalid & s_axi_wready;
        bh       = s_axi_bvalid & s_axi_bready;
        sl_aw    = m_axi_awvalid & m_axi_awready;
        sl_w     = m_axi_wvalid & m_axi_wready;
        sl_b     = m_axi_bvalid & m_axi_bready;
        cap_addr = m_axi_awaddr;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            case (ph[i])
                0: if (left[i] > 0) begin
                    if (gap[i] == 0) begin
                        t.addr = $urandom;
                        t.prot = 3'($urandom);
                        t.data = $urandom;
                        t.strb = 4'($urandom);
                        exp_q[i].push_back(t);
                        cur_tx[i] = t;
                        awd[i] = $urandom_range(4);
                        wd[i]  = $urandom_range(4);
                        aws[i] = 1'b0;
                        ws[i]  = 1'b0;
                        ph[i]  = 1;
                    end else gap[i]--;
                end
                1: begin
                    if (awh[i]) begin s_axi_awvalid[i] = 1'b0; aws[i] = 1'b1; end
                    if (wh[i])  begin s_axi_wvalid[i]  = 1'b0; ws[i]  = 1'b1; end
                    if (!aws[i] && !s_axi_awvalid[i]) begin
                        if (awd[i] == 0) begin
                            s_axi_awvalid[i]         = 1'b1;
                            s_axi_awaddr[i*AW +: AW] = cur_tx[i].addr;
                            s_axi_awprot[i*3 +: 3]   = cur_tx[i].prot;
                        end else awd[i]--;
                    end
                    if (!ws[i] && !s_axi_wvalid[i]) begin
                        if (wd[i] == 0) begin
                            s_axi_wvalid[i]         = 1'b1;
                            s_axi_wdata[i*BW +: BW] = cur_tx[i].data;
                            s_axi_wstrb[i*SW +: SW] = cur_tx[i].strb;
                        end else wd[i]--;
                    end
                    if (aws[i] && ws[i]) ph[i] = 2;
                end
                default: begin
                    if (bh[i]) begin
                        ph[i]   = 0;
                        left[i]--;
                        gap[i]  = $urandom_range(6);
                        s_axi_bready[i] = 1'b0;
                    end else s_axi_bready[i] = ($urandom_range(99) < brdy_pct);
                end
            endcase
        end
        if (sl_aw) begin s_gaw = 1'b1; s_addr = cap_addr; end
        if (sl_w) s_gw = 1'b1;
        if (sl_b) begin
            m_axi_bvalid = 1'b0;
            s_gaw = 1'b0;
            s_gw  = 1'b0;
            s_bd  = $urandom_range(max_bd);
        end else if (s_gaw && s_gw && !m_axi_bvalid) begin
            if (s_bd == 0) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = s_addr[3:2];
            end else s_bd--;
        end
        m_axi_awready = ($urandom_range(99) < rdy_pct);
        m_axi_wready  = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = !s_gaw && !s_gw && !m_axi_bvalid;
            for (int i = 0; i < N; i++) if (left[i] != 0 || ph[i] != 0) done = 1'b0;
        end
        chk("phase_timeout", 64'(done), 64'd1);
    endtask

    initial begin : main
        int  n;
        bit  hs;
        int  remaining;
        reset = 1'b1;
        s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_bready = '0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = '0;
        s_gaw = 1'b0; s_gw = 1'b0; s_addr = '0; s_bd = 0;
        for (int i = 0; i < N; i++) begin
            ph[i] = 0; gap[i] = 0; awd[i] = 0; wd[i] = 0; left[i] = 0;
            aws[i] = 1'b0; ws[i] = 1'b0; cur_tx[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(|{grant, busy, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                                   m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // single transaction from master 2 with an always-ready slave
        rdy_pct = 100; brdy_pct = 100; max_bd = 0;
        left[2] = 1;
        run_until_done(100);

        // all masters, random gaps, random ready/valid timing
        rdy_pct = 60; brdy_pct = 60; max_bd = 3;
        for (int i = 0; i < N; i++) begin
            left[i] = 20;
            gap[i]  = $urandom_range(3);
        end
        run_until_done(20000);
        repeat (2) step();
        remaining = 0;
        for (int i = 0; i < N; i++) remaining += exp_q[i].size();
        chk("scoreboard_drained", 64'(remaining), 64'd0);

        // reset in XFER after only the AW handshake
        mon_en = 1'b0;
        s_axi_bready  = '0;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b0;
        s_axi_awvalid[3] = 1'b1;
        s_axi_awaddr[3*AW +: AW] = 32'h30;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 10) begin
            @(negedge clk);
            hs = s_axi_awvalid[3] & s_axi_awready[3];
            n++;
            @(posedge clk);
            #1;
        end
        chk("rst_test_aw_hs", 64'(hs), 64'd1);
        s_axi_awvalid[3] = 1'b0;
        m_axi_awready    = 1'b0;
        #2;
        chk("rst_test_in_xfer", 64'({busy, grant}), 64'({1'b1, 4'b1000}));
        reset = 1'b1;
        #1;
        chk("rst_abort_grant", 64'({busy, grant}), 64'd0);
        chk("rst_abort_outputs", 64'(|{s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                                       m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid,
                                       m_axi_wdata, m_axi_wstrb, m_axi_bready}), 64'd0);
        s_axi_awvalid[0] = 1'b1;
        s_axi_awvalid[3] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 64'(grant), 64'd0);
        @(negedge clk);
        chk("post_rst_master0_first", 64'(grant), 64'(4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
